// File: rtl/axil_pkg.sv
// Shared encodings for the AXI4-Lite load/store unit: AXI responses, LSU error codes,
// access sizes and the FSM state type.
package axil_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    LSU_ERR_NONE     = 2'd0,
    LSU_ERR_MISALIGN = 2'd1,
    LSU_ERR_SLVERR   = 2'd2,
    LSU_ERR_DECERR   = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // OKAY and EXOKAY both count as success for a single-beat access.
  function automatic lsu_err_e resp_to_err(input logic [1:0] resp);
    case (resp)
      AXI_SLVERR: return LSU_ERR_SLVERR;
      AXI_DECERR: return LSU_ERR_DECERR;
      default:    return LSU_ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between right-aligned core data and the AXI data bus.
// Store side: shifts data into its lane and builds the write strobe.
// Load side: extracts the addressed bytes and sign/zero extends them.
module lsu_lane_align #(
  parameter int DATA_WIDTH = 32,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int LANE_W = $clog2(STRB_W)
) (
  input  logic [LANE_W-1:0]     lane_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [STRB_W-1:0]     wstrb_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  import axil_pkg::*;

  logic [STRB_W-1:0]     strb_base;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic                  fill;
  int                    nbits;

  // Strobe pattern for the access size before it is moved into its lane.
  always_comb begin
    strb_base = '0;
    case (size_i)
      SIZE_B:  strb_base = STRB_W'(8'h01);
      SIZE_H:  strb_base = STRB_W'(8'h03);
      SIZE_W:  strb_base = STRB_W'(8'h0F);
      default: strb_base = STRB_W'(8'hFF);
    endcase
  end

  assign wstrb_o = strb_base << lane_i;
  assign wdata_o = wdata_i << {lane_i, 3'b000};

  // Bring the addressed bytes down to bit 0, then overwrite everything above the access width.
  always_comb begin
    rd_shifted = rdata_i >> {lane_i, 3'b000};
    nbits      = 8 << size_i;
    case (size_i)
      SIZE_B:  fill = rd_shifted[7];
      SIZE_H:  fill = rd_shifted[15];
      SIZE_W:  fill = rd_shifted[31];
      default: fill = 1'b0;
    endcase
    if (unsigned_i) fill = 1'b0;
    rdata_o = rd_shifted;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= nbits) rdata_o[i] = fill;
    end
  end

endmodule

// File: rtl/axil_lsu.sv
// Load/store unit: single-outstanding core data request port to an AXI4-Lite master.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | ready for a request; misaligned requests go straight to RESP
//  ST_WR    | store: AW and/or W still waiting for their handshake
//  ST_WRESP | store: both channels done, bready high, waiting for B
//  ST_RADDR | load: arvalid high, waiting for arready
//  ST_RDATA | load: rready high, waiting for R
//  ST_RESP  | one-cycle rsp_valid pulse, then back to IDLE
module axil_lsu #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int LANE_W = $clog2(STRB_W)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,

  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,

  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_W-1:0]     m_axi_wstrb,

  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,

  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,

  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);
  import axil_pkg::*;

  lsu_state_e            state_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LANE_W-1:0]     lane_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  lsu_err_e              rsp_err_q;

  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] req_addr_aligned;
  logic                  aw_pending;
  logic                  w_pending;
  logic [DATA_WIDTH-1:0] ld_data;
  lsu_err_e              r_err;
  lsu_err_e              b_err;

  assign req_addr_aligned = {req_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
  assign aw_pending       = awvalid_q & ~m_axi_awready;
  assign w_pending        = wvalid_q & ~m_axi_wready;
  assign r_err            = resp_to_err(m_axi_rresp);
  assign b_err            = resp_to_err(m_axi_bresp);

  // Natural alignment check; dword accesses cannot exist on a 32-bit bus.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_H:  misaligned = req_addr[0];
      SIZE_W:  misaligned = |req_addr[1:0];
      SIZE_D:  misaligned = (DATA_WIDTH == 32) || (|req_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  // Lane steering works off the latched request so AXI payload stays stable while busy.
  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .wdata_o    (m_axi_wdata),
    .wstrb_o    (m_axi_wstrb),
    .rdata_i    (m_axi_rdata),
    .rdata_o    (ld_data)
  );

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= LSU_ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr_aligned;
            lane_q  <= req_addr[LANE_W-1:0];
            wdata_q <= req_wdata;
            if (misaligned) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= LSU_ERR_MISALIGN;
              rsp_rdata_q <= '0;
            end else if (req_we) begin
              state_q   <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= ST_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (!aw_pending && !w_pending) begin
            state_q  <= ST_WRESP;
            bready_q <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid) begin
            state_q     <= ST_RESP;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= b_err;
            rsp_rdata_q <= '0;
          end
        end
        ST_RADDR: begin
          if (m_axi_arready) begin
            state_q   <= ST_RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            state_q     <= ST_RESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= r_err;
            rsp_rdata_q <= (r_err == LSU_ERR_NONE) ? ld_data : '0;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_lsu.sv
// Directed bench for axil_lsu (32-bit data/address). The bench plays the AXI slave by hand.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axil_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fails  = 0;

  axil_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_bresp   (bresp),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Presents one request for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  // Store with AW/W ready immediately and B one cycle later: rsp_valid in the 4th cycle
  // counting the acceptance cycle as the 1st.
  task automatic store_fast(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] resp,
                            input logic [31:0] exp_awaddr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic [1:0] exp_err);
    chk({tag, "/req_ready"}, 64'(req_ready), 64'd1);
    issue(1'b1, size, 1'b0, addr, data);
    chk({tag, "/awvalid"}, 64'(awvalid), 64'd1);
    chk({tag, "/wvalid"},  64'(wvalid),  64'd1);
    chk({tag, "/awaddr"},  64'(awaddr),  64'(exp_awaddr));
    chk({tag, "/wstrb"},   64'(wstrb),   64'(exp_strb));
    chk({tag, "/wdata"},   64'(wdata & strb_mask(wstrb)), 64'(exp_wdata));
    chk({tag, "/arvalid"}, 64'(arvalid), 64'd0);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk({tag, "/bready"},  64'(bready),  64'd1);
    chk({tag, "/aw_drop"}, 64'(awvalid | wvalid), 64'd0);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "/rsp_err"},   64'(rsp_err),   64'(exp_err));
    chk({tag, "/rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "/bready_off"}, 64'(bready),   64'd0);
    tick();
    chk({tag, "/rsp_pulse"}, 64'(rsp_valid), 64'd0);
    chk({tag, "/ready_back"}, 64'(req_ready), 64'd1);
  endtask

  // Load with arready immediate and R one cycle later.
  task automatic load_fast(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] bus_data,
                           input logic [1:0] resp, input logic [31:0] exp_araddr,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    issue(1'b0, size, uns, addr, 32'h0);
    chk({tag, "/arvalid"}, 64'(arvalid), 64'd1);
    chk({tag, "/araddr"},  64'(araddr),  64'(exp_araddr));
    chk({tag, "/awvalid"}, 64'(awvalid), 64'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk({tag, "/rready"},  64'(rready),  64'd1);
    chk({tag, "/ar_drop"}, 64'(arvalid), 64'd0);
    rvalid = 1'b1; rdata = bus_data; rresp = resp;
    tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "/rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    chk({tag, "/rsp_err"},   64'(rsp_err),   64'(exp_err));
    chk({tag, "/rready_off"}, 64'(rready),   64'd0);
    tick();
    chk({tag, "/rsp_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  // Misaligned request: response in the cycle right after acceptance, no AXI valids.
  task automatic misaligned(input string tag, input logic we, input logic [1:0] size,
                            input logic [31:0] addr);
    issue(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "/rsp_err"},   64'(rsp_err),   64'd1);
    chk({tag, "/rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "/no_axi"},    64'({awvalid, wvalid, arvalid}), 64'd0);
    tick();
    chk({tag, "/rsp_pulse"}, 64'(rsp_valid), 64'd0);
    chk({tag, "/no_axi2"},   64'({awvalid, wvalid, arvalid}), 64'd0);
    chk({tag, "/ready"},     64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    tick(); tick();
    chk("rst/valids",    64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    chk("rst/rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst/rsp_err",   64'(rsp_err),   64'd0);
    reset = 1'b1;
    tick();
    chk("rst/req_ready", 64'(req_ready), 64'd1);
    chk("rst/prot",      64'({awprot, arprot}), 64'd0);

    // 1: SW 0x104, awready held off for 3 cycles, wready immediate.
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
    chk("sw_slow/awvalid", 64'(awvalid), 64'd1);
    chk("sw_slow/wvalid",  64'(wvalid),  64'd1);
    chk("sw_slow/awaddr",  64'(awaddr),  64'h104);
    chk("sw_slow/wstrb",   64'(wstrb),   64'hF);
    chk("sw_slow/wdata",   64'(wdata),   64'hDEAD_BEEF);
    chk("sw_slow/busy",    64'(req_ready), 64'd0);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("sw_slow/w_drop",  64'(wvalid),  64'd0);
    chk("sw_slow/aw_hold", 64'(awvalid), 64'd1);
    // A new request while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sw_slow/aw_stable", 64'(awvalid), 64'd1);
      chk("sw_slow/addr_stable", 64'(awaddr), 64'h104);
      chk("sw_slow/no_bready", 64'(bready), 64'd0);
    end
    req_valid = 1'b0;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("sw_slow/aw_drop", 64'(awvalid), 64'd0);
    chk("sw_slow/bready",  64'(bready),  64'd1);
    chk("sw_slow/arvalid", 64'(arvalid), 64'd0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("sw_slow/rsp_valid", 64'(rsp_valid), 64'd1);
    chk("sw_slow/rsp_err",   64'(rsp_err),   64'd0);
    tick();
    chk("sw_slow/rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("sw_slow/ready",     64'(req_ready), 64'd1);

    // 2: sub-word stores and lane steering.
    store_fast("sb_lane3", 2'd0, 32'h0000_0103, 32'h0000_00A5, 2'b00, 32'h100, 4'h8, 32'hA500_0000, 2'd0);
    store_fast("sh_lane2", 2'd1, 32'h0000_0106, 32'h0000_1234, 2'b00, 32'h104, 4'hC, 32'h1234_0000, 2'd0);
    store_fast("sb_lane1", 2'd0, 32'h0000_0011, 32'h0000_007E, 2'b01, 32'h010, 4'h2, 32'h0000_7E00, 2'd0);

    // 3: loads with extension.
    load_fast("lh_signed",   2'd1, 1'b0, 32'h0000_0102, 32'h8001_0000, 2'b00, 32'h100, 32'hFFFF_8001, 2'd0);
    load_fast("lh_unsigned", 2'd1, 1'b1, 32'h0000_0102, 32'h8001_0000, 2'b00, 32'h100, 32'h0000_8001, 2'd0);
    load_fast("lb_signed",   2'd0, 1'b0, 32'h0000_0101, 32'h1234_8056, 2'b00, 32'h100, 32'hFFFF_FF80, 2'd0);
    load_fast("lbu_lane3",   2'd0, 1'b1, 32'h0000_0203, 32'h9A00_0000, 2'b00, 32'h200, 32'h0000_009A, 2'd0);
    load_fast("lw_exokay",   2'd2, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 2'b01, 32'h300, 32'hCAFE_F00D, 2'd0);

    // 4: misaligned requests.
    misaligned("lw_mis", 1'b0, 2'd2, 32'h0000_0102);
    misaligned("sh_mis", 1'b1, 2'd1, 32'h0000_0101);
    misaligned("ld_dword32", 1'b0, 2'd3, 32'h0000_0100);

    // 5: AXI error responses.
    load_fast("lw_decerr",  2'd2, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF, 2'b11, 32'h400, 32'h0, 2'd3);
    store_fast("sw_slverr", 2'd2, 32'h0000_0408, 32'h1111_2222, 2'b10, 32'h408, 4'hF, 32'h1111_2222, 2'd2);

    // 6: reset while waiting for R.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rst_mid/rready_pre", 64'(rready), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid/outputs", 64'({arvalid, rready, rsp_valid, awvalid, wvalid, bready}), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid/req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid/rsp_valid", 64'(rsp_valid), 64'd0);
    store_fast("post_rst_sw", 2'd2, 32'h0000_0600, 32'h0BAD_F00D, 2'b00, 32'h600, 4'hF, 32'h0BAD_F00D, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
